pwm_sweep_ctrl: RTL



---
 rtl/pwm_sweep_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/pwm_sweep_ctrl.sv
// Phase sequencer for the sine-LUT PWM path: half-sine theta sweep, rest pause, repeat or stop.
// Define PWM_SWEEP_SYNC_UPD_EN to defer theta steps to the next pwm_wrap pulse.
module pwm_sweep_ctrl #(
  parameter int unsigned STEP_DIV  = 5000000,
  parameter int unsigned N_STEPS   = 89,
  parameter int unsigned PAUSE_CYC = 500000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       continuous,
  input  logic       pwm_wrap,
  output logic [9:0] theta,
  output logic       theta_upd,
  output logic       busy,
  output logic       sweep_done,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RAMP  = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  localparam logic [31:0] DIV_LAST   = 32'(STEP_DIV - 1);
  localparam logic [9:0]  THETA_LAST = 10'(N_STEPS - 1);
  localparam logic [31:0] PAUSE_LAST = 32'(PAUSE_CYC - 1);
  localparam bit          HAS_PAUSE  = (PAUSE_CYC != 0);

  state_t      state_q, state_d;
  logic [9:0]  theta_q, theta_d;
  logic [31:0] div_cnt_q, div_cnt_d;
  logic [31:0] pause_cnt_q, pause_cnt_d;
  logic        theta_upd_q, theta_upd_d;
  logic        sweep_done_q, sweep_done_d;
  logic        busy_q, busy_d;
  logic        step_due;
  logic        step_go;

`ifdef PWM_SWEEP_SYNC_UPD_EN
  logic        pend_q, pend_d;
`else
  logic        wrap_unused;
  assign wrap_unused = pwm_wrap;
`endif

  assign step_due = (div_cnt_q == DIV_LAST);

  always_comb begin
    state_d      = state_q;
    theta_d      = theta_q;
    div_cnt_d    = div_cnt_q;
    pause_cnt_d  = pause_cnt_q;
    theta_upd_d  = 1'b0;
    sweep_done_d = 1'b0;
    step_go      = 1'b0;
`ifdef PWM_SWEEP_SYNC_UPD_EN
    pend_d       = pend_q;
`endif
    if (stop) begin
      state_d     = S_IDLE;
      theta_d     = '0;
      div_cnt_d   = '0;
      pause_cnt_d = '0;
      theta_upd_d = (theta_q != '0);
`ifdef PWM_SWEEP_SYNC_UPD_EN
      pend_d      = 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          theta_d     = '0;
          div_cnt_d   = '0;
          pause_cnt_d = '0;
          if (start) begin
            state_d     = S_RAMP;
            theta_upd_d = 1'b1;
`ifdef PWM_SWEEP_SYNC_UPD_EN
            pend_d      = 1'b0;
`endif
          end
        end
        S_RAMP: begin
`ifdef PWM_SWEEP_SYNC_UPD_EN
          // A due step parks with div_cnt frozen until the PWM period wraps.
          if (pend_q || step_due) begin
            if (pwm_wrap) begin
              step_go = 1'b1;
              pend_d  = 1'b0;
            end else begin
              pend_d  = 1'b1;
            end
          end else begin
            div_cnt_d = div_cnt_q + 32'd1;
          end
`else
          if (step_due) begin
            step_go = 1'b1;
          end else begin
            div_cnt_d = div_cnt_q + 32'd1;
          end
`endif
          if (step_go) begin
            div_cnt_d   = '0;
            theta_upd_d = 1'b1;
            if (theta_q == THETA_LAST) begin
              theta_d      = '0;
              sweep_done_d = 1'b1;
              if (HAS_PAUSE) begin
                state_d     = S_PAUSE;
                pause_cnt_d = '0;
              end else if (!continuous) begin
                state_d = S_IDLE;
              end
            end else begin
              theta_d = theta_q + 10'd1;
            end
          end
        end
        S_PAUSE: begin
          theta_d = '0;
          if (pause_cnt_q == PAUSE_LAST) begin
            pause_cnt_d = '0;
            div_cnt_d   = '0;
            state_d     = continuous ? S_RAMP : S_IDLE;
          end else begin
            pause_cnt_d = pause_cnt_q + 32'd1;
          end
        end
        default: begin
          state_d     = S_IDLE;
          theta_d     = '0;
          div_cnt_d   = '0;
          pause_cnt_d = '0;
        end
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      theta_q      <= '0;
      div_cnt_q    <= '0;
      pause_cnt_q  <= '0;
      theta_upd_q  <= 1'b0;
      sweep_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      theta_q      <= theta_d;
      div_cnt_q    <= div_cnt_d;
      pause_cnt_q  <= pause_cnt_d;
      theta_upd_q  <= theta_upd_d;
      sweep_done_q <= sweep_done_d;
      busy_q       <= busy_d;
    end
  end

`ifdef PWM_SWEEP_SYNC_UPD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end
`endif

  assign theta      = theta_q;
  assign theta_upd  = theta_upd_q;
  assign busy       = busy_q;
  assign sweep_done = sweep_done_q;
  assign state      = state_q;

endmodule
